// File: rtl/gen2_inventory_ctrl.sv
// Gen2 tag-side inventory/access state controller.
// Sequences the tag state, Q, slot counter and RN16/handle for each decoded
// packet and issues at most one reply request per accepted packet.
// Optional feature macro: SLOT_TIMEOUT_EN (REPLY/ACKNOWLEDGED idle fallback).
module gen2_inventory_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        packet_complete,
    input  logic [12:0] cmd_onehot,
    input  logic        crc5invalid,
    input  logic        crc16invalid,
    input  logic [3:0]  q_new,
    input  logic [2:0]  qadj_updn,
    input  logic [15:0] rn_in,
    input  logic        handle_match,
    input  logic        tx_done,
    output logic [2:0]  state,
    output logic [14:0] slot,
    output logic [3:0]  q,
    output logic [15:0] handle,
    output logic        reply_req,
    output logic [2:0]  reply_type,
    output logic        reply_busy
);

    typedef enum logic [2:0] {
        READY        = 3'd0,
        ARBITRATE    = 3'd1,
        REPLY        = 3'd2,
        ACKNOWLEDGED = 3'd3,
        OPEN         = 3'd4
    } tag_state_t;

    localparam logic [2:0] RT_NONE   = 3'd0;
    localparam logic [2:0] RT_RN16   = 3'd1;
    localparam logic [2:0] RT_EPC    = 3'd2;
    localparam logic [2:0] RT_HANDLE = 3'd3;
    localparam logic [2:0] RT_READ   = 3'd4;
    localparam logic [2:0] RT_WRITE  = 3'd5;
    localparam logic [2:0] RT_SENSOR = 3'd6;

    localparam logic [14:0] SLOT_MAX = 15'h7FFF;

    // The idle counter is 11 bits wide, so the threshold must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2047) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 11-bit idle counter");
    end

    tag_state_t  cur_st, nst;
    logic [14:0] nslot;
    logic [3:0]  nq;
    logic [15:0] nhandle;
    logic [2:0]  rtype;
    logic        acc;
    logic [3:0]  cmd_idx;
    logic        busy_eff;
    logic        updn_ok;
    logic [3:0]  q_adj;
    logic [3:0]  q_eff;
    logic [14:0] draw_slot;
    logic        crc_ok;

`ifdef SLOT_TIMEOUT_EN
    localparam logic [10:0] TMO_LAST = 11'(TIMEOUT_CYCLES - 1);
    logic [10:0] idle_cnt;
    logic        idle_run;
    logic        tmo_fire;
`endif

    assign state = cur_st;

    // Next-state decision for the packet presented this cycle
    always_comb begin
        // lowest set command bit wins
        cmd_idx = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (cmd_onehot[i]) cmd_idx = 4'(i);
        end
        // a tx_done on the same edge frees the controller for this packet
        busy_eff = reply_busy && !tx_done;

        updn_ok = 1'b1;
        case (qadj_updn)
            3'b110:  q_adj = (q == 4'd15) ? 4'd15 : q + 4'd1;
            3'b011:  q_adj = (q == 4'd0) ? 4'd0 : q - 4'd1;
            3'b000:  q_adj = q;
            default: begin
                q_adj   = q;
                updn_ok = 1'b0;
            end
        endcase
        q_eff     = (cmd_idx == 4'd2) ? q_new : q_adj;
        draw_slot = rn_in[14:0] & ~(SLOT_MAX << q_eff);
        crc_ok    = !crc16invalid || !(cmd_idx == 4'd7 || cmd_idx == 4'd8 || cmd_idx == 4'd11);

        acc     = 1'b0;
        nst     = cur_st;
        nslot   = slot;
        nq      = q;
        nhandle = handle;
        rtype   = RT_NONE;

        if (packet_complete && !busy_eff && (cmd_onehot != 13'd0)) begin
            case (cmd_idx)
                4'd0: begin // QueryRep
                    if (cur_st == ARBITRATE) begin
                        acc   = 1'b1;
                        nslot = slot - 15'd1; // 0 wraps to 7FFF
                        if (slot == 15'd1) begin
                            nst     = REPLY;
                            nhandle = rn_in;
                            rtype   = RT_RN16;
                        end
                    end else if (cur_st == REPLY) begin
                        acc   = 1'b1;
                        nst   = ARBITRATE;
                        nslot = SLOT_MAX;
                    end else if (cur_st == ACKNOWLEDGED || cur_st == OPEN) begin
                        acc = 1'b1;
                        nst = READY;
                    end
                end
                4'd1: begin // Ack
                    if (cur_st inside {REPLY, ACKNOWLEDGED, OPEN}) begin
                        acc = 1'b1;
                        if (handle_match) begin
                            if (cur_st != OPEN) nst = ACKNOWLEDGED;
                            rtype = RT_EPC;
                        end else begin
                            nst   = ARBITRATE;
                            nslot = SLOT_MAX;
                        end
                    end
                end
                4'd2: begin // Query
                    if (!crc5invalid) begin
                        acc   = 1'b1;
                        nq    = q_new;
                        nslot = draw_slot;
                        if (draw_slot == 15'd0) begin
                            nst     = REPLY;
                            nhandle = rn_in;
                            rtype   = RT_RN16;
                        end else begin
                            nst = ARBITRATE;
                        end
                    end
                end
                4'd3: begin // QueryAdj
                    if (updn_ok) begin
                        if (cur_st == ARBITRATE || cur_st == REPLY) begin
                            acc   = 1'b1;
                            nq    = q_adj;
                            nslot = draw_slot;
                            if (draw_slot == 15'd0) begin
                                nst     = REPLY;
                                nhandle = rn_in;
                                rtype   = RT_RN16;
                            end else begin
                                nst = ARBITRATE;
                            end
                        end else if (cur_st == ACKNOWLEDGED || cur_st == OPEN) begin
                            acc = 1'b1;
                            nst = READY;
                        end
                    end
                end
                4'd4: begin // Select
                    if (!crc16invalid) begin
                        acc = 1'b1;
                        nst = READY;
                    end
                end
                4'd5: begin // Nack
                    if (cur_st != READY) begin
                        acc   = 1'b1;
                        nst   = ARBITRATE;
                        nslot = SLOT_MAX;
                    end
                end
                4'd6: begin // ReqRN
                    if (!crc16invalid && handle_match) begin
                        if (cur_st == ACKNOWLEDGED) begin
                            acc     = 1'b1;
                            nhandle = rn_in;
                            nst     = OPEN;
                            rtype   = RT_HANDLE;
                        end else if (cur_st == OPEN) begin
                            acc   = 1'b1;
                            rtype = RT_RN16;
                        end
                    end
                end
                default: begin // Read, Write, sensor/custom
                    if (cur_st == OPEN && handle_match && crc_ok) begin
                        acc = 1'b1;
                        if (cmd_idx == 4'd7)      rtype = RT_READ;
                        else if (cmd_idx == 4'd8) rtype = RT_WRITE;
                        else                      rtype = RT_SENSOR;
                    end
                end
            endcase
        end

`ifdef SLOT_TIMEOUT_EN
        idle_run = (cur_st == REPLY || cur_st == ACKNOWLEDGED) && !reply_busy && !acc;
        tmo_fire = idle_run && (idle_cnt == TMO_LAST);
        if (tmo_fire) begin
            nst   = ARBITRATE;
            nslot = SLOT_MAX;
        end
`endif
    end

    // Tag state, counters and reply handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_st     <= READY;
            slot       <= 15'd0;
            q          <= 4'd0;
            handle     <= 16'd0;
            reply_req  <= 1'b0;
            reply_type <= RT_NONE;
            reply_busy <= 1'b0;
`ifdef SLOT_TIMEOUT_EN
            idle_cnt   <= 11'd0;
`endif
        end else begin
            cur_st    <= nst;
            slot      <= nslot;
            q         <= nq;
            handle    <= nhandle;
            reply_req <= (rtype != RT_NONE);
            if (rtype != RT_NONE) begin
                reply_type <= rtype;
                reply_busy <= 1'b1;
            end else if (tx_done) begin
                reply_busy <= 1'b0;
            end
`ifdef SLOT_TIMEOUT_EN
            if (!idle_run || tmo_fire) idle_cnt <= 11'd0;
            else                       idle_cnt <= idle_cnt + 11'd1;
`endif
        end
    end

endmodule

// File: tb/tb_gen2_inventory_ctrl.sv
// Scoreboard bench for gen2_inventory_ctrl: every packet pushes the expected
// post-decision snapshot; the monitor pops and compares it on the cycle the
// decision becomes visible. Optional SLOT_TIMEOUT_EN build uses 16 cycles.
module tb_gen2_inventory_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic [14:0] slot;
        logic [3:0]  q;
        logic [15:0] handle;
        logic        req;
        logic [2:0]  rtype;
        logic        busy;
    } snap_t;

    localparam logic [12:0] C_QREP  = 13'h0001;
    localparam logic [12:0] C_ACK   = 13'h0002;
    localparam logic [12:0] C_QUERY = 13'h0004;
    localparam logic [12:0] C_QADJ  = 13'h0008;
    localparam logic [12:0] C_SEL   = 13'h0010;
    localparam logic [12:0] C_NACK  = 13'h0020;
    localparam logic [12:0] C_REQRN = 13'h0040;
    localparam logic [12:0] C_READ  = 13'h0080;
    localparam logic [12:0] C_WRITE = 13'h0100;
    localparam logic [12:0] C_CUS9  = 13'h0200;
    localparam logic [12:0] C_CUS12 = 13'h1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        packet_complete = 1'b0;
    logic [12:0] cmd_onehot = '0;
    logic        crc5invalid = 1'b0;
    logic        crc16invalid = 1'b0;
    logic [3:0]  q_new = '0;
    logic [2:0]  qadj_updn = '0;
    logic [15:0] rn_in = '0;
    logic        handle_match = 1'b0;
    logic        tx_done = 1'b0;
    logic [2:0]  state;
    logic [14:0] slot;
    logic [3:0]  q;
    logic [15:0] handle;
    logic        reply_req;
    logic [2:0]  reply_type;
    logic        reply_busy;

    int    checks = 0;
    int    errors = 0;
    int    pkt_no = 0;
    snap_t exp_q[$];
    logic  pc_d = 1'b0;

    gen2_inventory_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .packet_complete(packet_complete),
        .cmd_onehot(cmd_onehot), .crc5invalid(crc5invalid), .crc16invalid(crc16invalid),
        .q_new(q_new), .qadj_updn(qadj_updn), .rn_in(rn_in), .handle_match(handle_match),
        .tx_done(tx_done), .state(state), .slot(slot), .q(q), .handle(handle),
        .reply_req(reply_req), .reply_type(reply_type), .reply_busy(reply_busy)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic [2:0] st, input logic [14:0] sl, input logic [3:0] qq,
                                 input logic [15:0] h, input logic rq, input logic [2:0] rt, input logic b);
        snap_t s;
        s.st = st; s.slot = sl; s.q = qq; s.handle = h; s.req = rq; s.rtype = rt; s.busy = b;
        return s;
    endfunction

    function automatic snap_t now();
        return mk(state, slot, q, handle, reply_req, reply_type, reply_busy);
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d slot=%h q=%0d h=%h req=%b type=%0d busy=%b, want st=%0d slot=%h q=%0d h=%h req=%b type=%0d busy=%b",
                     name, act.st, act.slot, act.q, act.handle, act.req, act.rtype, act.busy,
                     exp.st, exp.slot, exp.q, exp.handle, exp.req, exp.rtype, exp.busy);
        end
    endtask

    // Marks the cycles whose edge sampled a packet
    always @(posedge clk) pc_d <= packet_complete;

    // Monitor: compare the decision snapshot, and flag spurious reply requests
    always @(negedge clk) begin
        if (pc_d) begin
            pkt_no++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pkt%0d: no expected entry queued", pkt_no);
            end else begin
                check($sformatf("pkt%0d", pkt_no), now(), exp_q.pop_front());
            end
        end else if (reply_req === 1'b1) begin
            errors++;
            $display("FAIL spurious_req: reply_req=1 without a packet, required 0");
        end
    end

    task automatic pkt(input logic [12:0] oh, input logic [3:0] qn, input logic [2:0] ud,
                       input logic [15:0] rn, input logic hm, input logic c5, input logic c16,
                       input logic txd, input snap_t e);
        @(negedge clk);
        cmd_onehot = oh; q_new = qn; qadj_updn = ud; rn_in = rn; handle_match = hm;
        crc5invalid = c5; crc16invalid = c16; tx_done = txd; packet_complete = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        packet_complete = 1'b0; tx_done = 1'b0; cmd_onehot = '0;
        crc5invalid = 1'b0; crc16invalid = 1'b0; handle_match = 1'b0;
    endtask

    task automatic tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset", now(), mk(0, 0, 0, 16'h0000, 0, 0, 0));

        // first Query with Q=0 replies immediately, packet during busy ignored
        pkt(C_QUERY, 4'd0, 3'b000, 16'h1234, 0, 0, 0, 0, mk(2, 0, 0, 16'h1234, 1, 1, 1));
        pkt(C_QREP,  4'd0, 3'b000, 16'h9999, 0, 0, 0, 0, mk(2, 0, 0, 16'h1234, 0, 1, 1));
        tx();
        pkt(C_QUERY, 4'd3, 3'b000, 16'h0000, 0, 1, 0, 0, mk(2, 0, 0, 16'h1234, 0, 1, 0));
        // slot countdown
        pkt(C_QUERY, 4'd3, 3'b000, 16'h0005, 0, 0, 0, 0, mk(1, 5, 3, 16'h1234, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 4, 3, 16'h1234, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 3, 3, 16'h1234, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 2, 3, 16'h1234, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 1, 3, 16'h1234, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'hA001, 0, 0, 0, 0, mk(2, 0, 3, 16'hA001, 1, 1, 1));
        // Ack with tx_done on the same edge, then access sequence
        pkt(C_ACK,   4'd0, 3'b000, 16'h0000, 1, 0, 0, 1, mk(3, 0, 3, 16'hA001, 1, 2, 1));
        tx();
        pkt(C_REQRN, 4'd0, 3'b000, 16'hBEEF, 1, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 1, 3, 1));
        tx();
        pkt(C_READ,  4'd0, 3'b000, 16'h0000, 1, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 1, 4, 1));
        tx();
        pkt(C_WRITE, 4'd0, 3'b000, 16'h0000, 1, 0, 1, 0, mk(4, 0, 3, 16'hBEEF, 0, 4, 0));
        pkt(C_READ,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 0, 4, 0));
        pkt(C_CUS9 | C_CUS12, 4'd0, 3'b000, 16'h0000, 1, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 1, 6, 1));
        tx();
        pkt(C_REQRN, 4'd0, 3'b000, 16'h1111, 1, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 1, 1, 1));
        tx();
        pkt(C_ACK | C_READ, 4'd0, 3'b000, 16'h0000, 1, 0, 0, 0, mk(4, 0, 3, 16'hBEEF, 1, 2, 1));
        tx();
        pkt(C_QADJ,  4'd0, 3'b110, 16'h0000, 0, 0, 0, 0, mk(0, 0, 3, 16'hBEEF, 0, 2, 0));
        pkt(C_NACK,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(0, 0, 3, 16'hBEEF, 0, 2, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(0, 0, 3, 16'hBEEF, 0, 2, 0));
        // Q saturation and reserved UpDn
        pkt(C_QUERY, 4'd15, 3'b000, 16'h8003, 0, 0, 0, 0, mk(1, 15'h0003, 15, 16'hBEEF, 0, 2, 0));
        pkt(C_QADJ,  4'd0, 3'b110, 16'hFFFF, 0, 0, 0, 0, mk(1, 15'h7FFF, 15, 16'hBEEF, 0, 2, 0));
        pkt(C_QADJ,  4'd0, 3'b101, 16'h0000, 0, 0, 0, 0, mk(1, 15'h7FFF, 15, 16'hBEEF, 0, 2, 0));
        pkt(C_QUERY, 4'd0, 3'b000, 16'h0F0F, 0, 0, 0, 0, mk(2, 0, 0, 16'h0F0F, 1, 1, 1));
        tx();
        pkt(C_QADJ,  4'd0, 3'b011, 16'h2222, 0, 0, 0, 0, mk(2, 0, 0, 16'h2222, 1, 1, 1));
        tx();
        // Ack mismatch, decrement from 7FFF
        pkt(C_ACK,   4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 15'h7FFF, 0, 16'h2222, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 15'h7FFE, 0, 16'h2222, 0, 1, 0));
        pkt(C_QUERY, 4'd2, 3'b000, 16'h0002, 0, 0, 0, 0, mk(1, 2, 2, 16'h2222, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 1, 2, 16'h2222, 0, 1, 0));
        pkt(C_QREP,  4'd0, 3'b000, 16'h3333, 0, 0, 0, 0, mk(2, 0, 2, 16'h3333, 1, 1, 1));
        tx();
        pkt(C_QADJ,  4'd0, 3'b000, 16'h0006, 0, 0, 0, 0, mk(1, 2, 2, 16'h3333, 0, 1, 0));
        // Select
        pkt(C_SEL,   4'd0, 3'b000, 16'h0000, 0, 0, 1, 0, mk(1, 2, 2, 16'h3333, 0, 1, 0));
        pkt(C_SEL,   4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(0, 2, 2, 16'h3333, 0, 1, 0));
        // Nack and QueryRep out of REPLY
        pkt(C_QUERY, 4'd0, 3'b000, 16'h4444, 0, 0, 0, 0, mk(2, 0, 0, 16'h4444, 1, 1, 1));
        tx();
        pkt(C_NACK,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 15'h7FFF, 0, 16'h4444, 0, 1, 0));
        pkt(C_QUERY, 4'd0, 3'b000, 16'h5555, 0, 0, 0, 0, mk(2, 0, 0, 16'h5555, 1, 1, 1));
        tx();
        pkt(C_QREP,  4'd0, 3'b000, 16'h0000, 0, 0, 0, 0, mk(1, 15'h7FFF, 0, 16'h5555, 0, 1, 0));
        // idle in REPLY
        pkt(C_QUERY, 4'd0, 3'b000, 16'h7777, 0, 0, 0, 0, mk(2, 0, 0, 16'h7777, 1, 1, 1));
        tx();
`ifdef SLOT_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("idle_before_timeout", now(), mk(2, 0, 0, 16'h7777, 0, 1, 0));
        @(negedge clk);
        check("idle_timeout", now(), mk(1, 15'h7FFF, 0, 16'h7777, 0, 1, 0));
`else
        repeat (100) @(negedge clk);
        check("idle_no_timeout", now(), mk(2, 0, 0, 16'h7777, 0, 1, 0));
`endif
        // reset while a reply is in flight
        pkt(C_QUERY, 4'd0, 3'b000, 16'h6666, 0, 0, 0, 0, mk(2, 0, 0, 16'h6666, 1, 1, 1));
        #2 reset_n = 1'b0;
        #1 check("reset_mid_reply", now(), mk(0, 0, 0, 16'h0000, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
